// File: rtl/memwb_arbiter_pkg.sv
// Shared definitions for the memory wishbone arbiter.
// Holds the default bus widths, the default outstanding-transfer limit and
// the arbiter FSM state encoding used by the RTL and by anything that
// decodes the debug state output.
package memwb_arbiter_pkg;

  localparam int NOR_ADDR_BITS  = 24;
  localparam int NOR_DATA_BITS  = 32;
  localparam int MAXOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/memwb_arbiter_ctr.sv
// wb_outstanding_ctr: counts wishbone transfers that have been accepted
// (stb taken) but not yet answered (ack/err).
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   inc_i          : a strobe was accepted by the slave this cycle
//   dec_i          : an ack or err was returned this cycle
//   count_o        : current number of outstanding transfers
//   full_o         : count_o == MAXOUT
//   empty_o        : count_o == 0
module wb_outstanding_ctr #(
  parameter int MAXOUT = 16,
  parameter int CW     = $clog2(MAXOUT + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] count_q, count_d;
  logic          inc_eff, dec_eff;

  assign full_o  = (count_q == CW'(MAXOUT));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A response with nothing outstanding is spurious and must not underflow;
  // an increment at the limit cannot happen (stb is gated) but is guarded.
  assign inc_eff = inc_i && !full_o;
  assign dec_eff = dec_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (inc_eff && !dec_eff) begin
      count_d = count_q + CW'(1);
    end else if (!inc_eff && dec_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memwb_arbiter.sv
// memwb_arbiter: two-master to one-slave wishbone (pipelined) arbiter for the
// NOR memory port. Master 0 is the QSPI front end, master 1 the auxiliary
// engine. A master keeps the bus for as long as its cyc is high; when it
// drops cyc with responses still pending the arbiter drains them (bus cyc
// held, stb low, responses swallowed) before returning to idle.
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   mN_* (N=0,1)          : wishbone master-side slave ports
//   s_*                   : wishbone master port toward the memory slave
//   grant_o               : one-hot current owner, 00 when idle/draining
//   dbg_state_o           : FSM state (arb_state_e encoding)
//   dbg_count_o           : outstanding transfer count
// Handshake: a beat is transferred on a cycle where stb is high and stall is
// low; every transferred beat is answered by exactly one ack or err cycle.
module memwb_arbiter
  import memwb_arbiter_pkg::*;
#(
  parameter int ADDRBITS = NOR_ADDR_BITS,
  parameter int DATABITS = NOR_DATA_BITS,
  parameter int MAXOUT   = MAXOUT_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          m0_cyc_i,
  input  logic                          m0_stb_i,
  input  logic                          m0_we_i,
  input  logic [ADDRBITS-1:0]           m0_adr_i,
  input  logic [DATABITS-1:0]           m0_dat_i,
  output logic                          m0_ack_o,
  output logic                          m0_err_o,
  output logic                          m0_stall_o,
  output logic [DATABITS-1:0]           m0_dat_o,
  input  logic                          m1_cyc_i,
  input  logic                          m1_stb_i,
  input  logic                          m1_we_i,
  input  logic [ADDRBITS-1:0]           m1_adr_i,
  input  logic [DATABITS-1:0]           m1_dat_i,
  output logic                          m1_ack_o,
  output logic                          m1_err_o,
  output logic                          m1_stall_o,
  output logic [DATABITS-1:0]           m1_dat_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDRBITS-1:0]           s_adr_o,
  output logic [DATABITS-1:0]           s_dat_o,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_stall_i,
  input  logic [DATABITS-1:0]           s_dat_i,
  output logic [1:0]                    grant_o,
  output logic [1:0]                    dbg_state_o,
  output logic [$clog2(MAXOUT+1)-1:0]   dbg_count_o
);

  localparam int CW = $clog2(MAXOUT + 1);

  arb_state_e    state_q, state_d;
  logic          last_served_q, last_served_d;
  logic [CW-1:0] count;
  logic          full, empty;

  wb_outstanding_ctr #(.MAXOUT(MAXOUT), .CW(CW)) u_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (s_stb_o && !s_stall_i),
    .dec_i   (s_ack_i || s_err_i),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ARB_IDLE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  // Next state. Ties in IDLE go to the master not served last; a granted
  // master is never preempted and an err never ends a grant.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_served_q ? ARB_GRANT0 : ARB_GRANT1;
        end else if (m0_cyc_i) begin
          state_d = ARB_GRANT0;
        end else if (m1_cyc_i) begin
          state_d = ARB_GRANT1;
        end
        if (state_d == ARB_GRANT0) last_served_d = 1'b0;
        if (state_d == ARB_GRANT1) last_served_d = 1'b1;
      end
      ARB_GRANT0: if (!m0_cyc_i) state_d = empty ? ARB_IDLE : ARB_DRAIN;
      ARB_GRANT1: if (!m1_cyc_i) state_d = empty ? ARB_IDLE : ARB_DRAIN;
      ARB_DRAIN:  if (empty) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Bus muxing. Responses are forwarded only when something is outstanding
  // so a spurious ack/err never reaches a master.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m0_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_dat_o   = '0;
    case (state_q)
      ARB_GRANT0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i && !full;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_stall_o = s_stall_i || full;
        m0_ack_o   = s_ack_i && !empty;
        m0_err_o   = s_err_i && !empty;
        m0_dat_o   = s_dat_i;
      end
      ARB_GRANT1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i && !full;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_stall_o = s_stall_i || full;
        m1_ack_o   = s_ack_i && !empty;
        m1_err_o   = s_err_i && !empty;
        m1_dat_o   = s_dat_i;
      end
      ARB_DRAIN: s_cyc_o = 1'b1;
      default: ;
    endcase
  end

  assign grant_o     = {state_q == ARB_GRANT1, state_q == ARB_GRANT0};
  assign dbg_state_o = state_q;
  assign dbg_count_o = count;

endmodule

// File: tb/tb_memwb_arbiter.sv
module tb_memwb_arbiter;
  import memwb_arbiter_pkg::*;

  localparam int AW = 24;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    cyc = '0, stb = '0, we = '0;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat [2];
  logic          m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_i = 1'b0, s_err_i = 1'b0, s_stall_i = 1'b0;
  logic [DW-1:0] s_dat_i = '0;
  logic [1:0]    grant_o, dbg_state_o;
  logic [4:0]    dbg_count_o;

  logic [1:0]    ack_v, stall_v;
  logic [DW-1:0] mdat [2];
  assign ack_v   = {m1_ack_o, m0_ack_o};
  assign stall_v = {m1_stall_o, m0_stall_o};
  assign mdat[0] = m0_dat_o;
  assign mdat[1] = m1_dat_o;

  memwb_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o), .dbg_count_o(dbg_count_o)
  );

  // ---------------- scoreboard state ----------------
  int            n_err = 0, n_chk = 0, n_acc = 0;
  int            left [2];
  logic          auto_ack = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            exp_m_q[$];
  logic [AW-1:0] slv_q[$];

  function automatic logic [DW-1:0] data_fn(logic [AW-1:0] a);
    return {8'h5A, a ^ 24'h00C3C3};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Bench slave: answers the oldest accepted beat with data derived from
  // the address it saw on the bus.
  task automatic slave_drive();
    s_ack_i = auto_ack && (slv_q.size() > 0);
    s_dat_i = s_ack_i ? data_fn(slv_q.pop_front()) : '0;
  endtask

  // One clock: observe handshakes/responses just after the current inputs
  // settle, step to the next falling edge, then drive the next inputs.
  task automatic cycle();
    int m;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (cyc[i] && stb[i] && !stall_v[i]) begin
        exp_q.push_back(data_fn(adr[i]));
        exp_m_q.push_back(i);
        left[i]--;
        adr[i] = adr[i] + 1'b1;
      end
    end
    if (s_stb_o && !s_stall_i) begin
      slv_q.push_back(s_adr_o);
      n_acc++;
    end
    if (|ack_v) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", {30'd0, ack_v}, 32'd0);
      end else begin
        m = ack_v[1] ? 1 : 0;
        check("rdata", mdat[m], exp_q.pop_front());
        check("ack_owner", m, exp_m_q.pop_front());
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) stb[i] = cyc[i] && (left[i] > 0);
    slave_drive();
  endtask

  task automatic start(int m, int n, logic [AW-1:0] a);
    cyc[m]  = 1'b1;
    left[m] = n;
    adr[m]  = a;
    stb[m]  = (n > 0);
  endtask

  task automatic run_until_done(string tag);
    int b;
    b = 0;
    while ((left[0] > 0 || left[1] > 0 || exp_q.size() > 0) && b < 80) begin
      cycle();
      b++;
    end
    check({tag, "_done"}, (b < 80), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc0, b;
    left[0] = 0; left[1] = 0;
    adr[0] = '0; adr[1] = '0; wdat[0] = 32'h1111_0000; wdat[1] = 32'h2222_0000;

    // Reset values
    #3;
    check("rst_grant", grant_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_m0_stall", m0_stall_o, 1);
    check("rst_m1_stall", m1_stall_o, 1);
    check("rst_state", dbg_state_o, ARB_IDLE);
    check("rst_count", dbg_count_o, 0);
    @(negedge clk);
    reset_i = 1'b0;

    // Single master, 4 pipelined reads
    auto_ack = 1'b1;
    start(0, 4, 24'h100);
    #1 check("t1_pre_grant", grant_o, 0);
    cycle();
    check("t1_grant", grant_o, 2'b01);
    b = 0;
    while ((left[0] > 0 || exp_q.size() > 0) && b < 20) begin
      check("t1_m1_stall", m1_stall_o, 1);
      cycle();
      b++;
    end
    check("t1_accepted", n_acc, 4);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cycle();
    check("t1_idle", dbg_state_o, ARB_IDLE);

    // Tie from reset: m0 first, then m1
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    start(0, 2, 24'h200);
    start(1, 2, 24'h300);
    cycle();
    check("t2_grant_m0", grant_o, 2'b01);
    check("t2_m1_stall", m1_stall_o, 1);
    b = 0;
    while ((left[0] > 0 || exp_q.size() > 0) && b < 20) begin
      cycle();
      b++;
    end
    check("t2_m1_untouched", left[1], 2);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cycle();
    check("t2_idle_gap", grant_o, 2'b00);
    cycle();
    check("t2_grant_m1", grant_o, 2'b10);
    run_until_done("t2");
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle();

    // Saturation: 20 reads, slave withholds ack
    auto_ack = 1'b0;
    start(1, 20, 24'h400);
    acc0 = n_acc;
    cycle();
    for (int i = 0; i < 16; i++) cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stb_gated", s_stb_o, 0);
      check("t3_stall_full", m1_stall_o, 1);
      cycle();
    end
    check("t3_accepted16", n_acc - acc0, 16);
    check("t3_count16", dbg_count_o, 16);
    auto_ack = 1'b1;
    slave_drive();
    #1 check("t3_stb_full_ack", s_stb_o, 0);
    cycle();
    #1;
    check("t3_stb_resume", s_stb_o, 1);
    check("t3_stall_release", m1_stall_o, 0);
    run_until_done("t3");
    check("t3_accepted20", n_acc - acc0, 20);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle();

    // Abort with 3 outstanding, then drain
    auto_ack = 1'b0;
    start(0, 3, 24'h500);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("t4_count3", dbg_count_o, 3);
    check("t4_exp3", exp_q.size(), 3);
    exp_q.delete();
    exp_m_q.delete();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    start(1, 1, 24'h600);
    cycle();
    check("t4_drain", dbg_state_o, ARB_DRAIN);
    check("t4_drain_grant", grant_o, 0);
    auto_ack = 1'b1;
    slave_drive();
    b = 0;
    while (dbg_state_o == ARB_DRAIN && b < 10) begin
      #1;
      check("t4_no_m0_ack", m0_ack_o, 0);
      check("t4_s_cyc", s_cyc_o, 1);
      check("t4_s_stb", s_stb_o, 0);
      cycle();
      b++;
    end
    check("t4_drain_len", b, 4);
    check("t4_idle", dbg_state_o, ARB_IDLE);
    cycle();
    check("t4_grant_m1", grant_o, 2'b10);
    run_until_done("t4");
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle();

    // Simultaneous inc/dec, then err
    auto_ack = 1'b0;
    start(0, 5, 24'h700);
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    check("t5_count5", dbg_count_o, 5);
    left[0] = 1; stb[0] = 1'b1;
    s_ack_i = 1'b1;
    s_dat_i = data_fn(slv_q.pop_front());
    cycle();
    check("t5_count_same", dbg_count_o, 5);
    s_err_i = 1'b1;
    #1;
    check("t5_m0_err", m0_err_o, 1);
    check("t5_m1_err", m1_err_o, 0);
    check("t5_m0_ack", m0_ack_o, 0);
    void'(slv_q.pop_front());
    void'(exp_q.pop_front());
    void'(exp_m_q.pop_front());
    cycle();
    s_err_i = 1'b0;
    check("t5_count4", dbg_count_o, 4);
    check("t5_still_granted", grant_o, 2'b01);
    auto_ack = 1'b1;
    slave_drive();
    run_until_done("t5");
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cycle();
    check("t5_idle", dbg_state_o, ARB_IDLE);

    // Async reset mid-GRANT1 with 7 outstanding
    auto_ack = 1'b0;
    start(1, 7, 24'h800);
    cycle();
    for (int i = 0; i < 7; i++) cycle();
    check("t6_count7", dbg_count_o, 7);
    check("t6_grant_m1", grant_o, 2'b10);
    #2 reset_i = 1'b1;
    #1;
    check("t6_rst_grant", grant_o, 0);
    check("t6_rst_s_cyc", s_cyc_o, 0);
    check("t6_rst_s_stb", s_stb_o, 0);
    check("t6_rst_s_adr", s_adr_o, 0);
    check("t6_rst_s_we", s_we_o, 0);
    check("t6_rst_m1_stall", m1_stall_o, 1);
    check("t6_rst_m0_stall", m0_stall_o, 1);
    check("t6_rst_m1_dat", m1_dat_o, 0);
    check("t6_rst_count", dbg_count_o, 0);
    check("t6_rst_state", dbg_state_o, ARB_IDLE);
    slv_q.delete();
    exp_q.delete();
    exp_m_q.delete();
    left[0] = 0; left[1] = 0;
    cyc = 2'b11; stb = 2'b00;
    @(negedge clk);
    reset_i = 1'b0;
    #1 check("t6_post_rst_idle", grant_o, 0);
    cycle();
    check("t6_tie_m0", grant_o, 2'b01);
    cyc = 2'b00;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
